// File: rtl/frame_pattern_streamer.sv
// frame_pattern_streamer: Avalon-ST raster frame source from an image ROM or generated test patterns.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   enable              allow a new frame to start
//   mode[2:0]           0 ROM, 1 solid, 2 gradient, 3 colour bars, 4 checkerboard, 5-7 as 0
//   solid_rgb           {R,G,B} colour for mode 1, IN_BITS per channel
//   data                {R,G,B} pixel, OUT_BITS per channel
//   startofpacket       high on the (0,0) beat
//   endofpacket         high on the (WIDTH-1,HEIGHT-1) beat
//   valid, ready        Avalon-ST handshake
//   frame_count         completed frames, wrapping
//   busy                high from SOP load until EOP accepted
module frame_pattern_streamer #(
    parameter int    WIDTH       = 320,
    parameter int    HEIGHT      = 240,
    parameter int    IN_BITS     = 4,
    parameter int    OUT_BITS    = 10,
    parameter string ROM_FILE    = "chad-ho320x240.mif",
    parameter int    GRAD_SHIFT  = 5,
    parameter int    CHECK_SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [2:0]            mode,
    input  logic [3*IN_BITS-1:0]  solid_rgb,
    output logic [3*OUT_BITS-1:0] data,
    output logic                  startofpacket,
    output logic                  endofpacket,
    output logic                  valid,
    input  logic                  ready,
    output logic [15:0]           frame_count,
    output logic                  busy
);
    localparam int PIX = WIDTH * HEIGHT;
    localparam int XW  = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int YW  = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam int AW  = PIX > 1 ? $clog2(PIX) : 1;
    localparam int CW  = 3 * IN_BITS;
    localparam int DW  = 3 * OUT_BITS;

    (* ram_init_file = ROM_FILE *) logic [CW-1:0] rom [PIX];

    logic [XW-1:0] x_q, x_d, s_x_q, s_x_d;
    logic [YW-1:0] y_q, y_d, s_y_q, s_y_d;
    logic [AW-1:0] a_q, a_d;
    logic          act_q, act_d, s_vld_q, s_vld_d;
    logic [2:0]    mode_q, mode_d;
    logic [CW-1:0] rgb_q, rgb_d, rom_q, pix;
    logic          vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, busy_q, busy_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          adv, fetch, start, last_x, last_y, s_sop, s_eop, acc_eop, chk;
    logic [2:0]    bar;
    logic [IN_BITS-1:0] g;

    function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
        logic [OUT_BITS-1:0] r;
        for (int i = 0; i < OUT_BITS; i++) r[OUT_BITS-1-i] = c[IN_BITS-1-(i%IN_BITS)];
        return r;
    endfunction

    // The whole two-stage pipe moves together, so a stalled output freezes fetch too.
    assign adv     = !vld_q || ready;
    assign fetch   = adv && (act_q || enable);
    assign start   = adv && !act_q && enable;
    assign last_x  = x_q == XW'(WIDTH - 1);
    assign last_y  = y_q == YW'(HEIGHT - 1);
    assign s_sop   = s_x_q == '0 && s_y_q == '0;
    assign s_eop   = s_x_q == XW'(WIDTH - 1) && s_y_q == YW'(HEIGHT - 1);
    assign acc_eop = vld_q && ready && eop_q;

    always_ff @(posedge clk) if (fetch) rom_q <= rom[a_q];

    // Bar index counts how many elaboration-time bar boundaries x has passed.
    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++) if (int'(s_x_q) >= k * WIDTH / 8) bar = 3'(k);
    end

    assign g   = IN_BITS'(32'(s_x_q) >> GRAD_SHIFT);
    assign chk = 1'((32'(s_x_q) >> CHECK_SHIFT) ^ (32'(s_y_q) >> CHECK_SHIFT));
    assign pix = mode_q == 3'd1 ? rgb_q :
                 mode_q == 3'd2 ? {g, g, g} :
                 mode_q == 3'd3 ? {{IN_BITS{!bar[1]}}, {IN_BITS{!bar[2]}}, {IN_BITS{!bar[0]}}} :
                 mode_q == 3'd4 ? {CW{chk}} : rom_q;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        a_d     = a_q;
        act_d   = act_q;
        mode_d  = start ? (mode > 3'd4 ? 3'd0 : mode) : mode_q;
        rgb_d   = start ? solid_rgb : rgb_q;
        s_vld_d = adv ? fetch : s_vld_q;
        s_x_d   = fetch ? x_q : s_x_q;
        s_y_d   = fetch ? y_q : s_y_q;
        if (fetch) begin
            x_d   = last_x ? '0 : x_q + 1'b1;
            y_d   = last_x ? (last_y ? '0 : y_q + 1'b1) : y_q;
            a_d   = last_x && last_y ? '0 : a_q + 1'b1;
            act_d = !(last_x && last_y);
        end
        vld_d  = adv ? s_vld_q : vld_q;
        sop_d  = adv ? s_vld_q && s_sop : sop_q;
        eop_d  = adv ? s_vld_q && s_eop : eop_q;
        dat_d  = adv && s_vld_q ? {expand(pix[CW-1-:IN_BITS]), expand(pix[2*IN_BITS-1-:IN_BITS]),
                                   expand(pix[IN_BITS-1:0])} : dat_q;
        cnt_d  = cnt_q + 16'(acc_eop);
        // A SOP loaded on the same edge as an EOP acceptance keeps busy asserted.
        busy_d = adv && s_vld_q && s_sop ? 1'b1 : acc_eop ? 1'b0 : busy_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            a_q     <= '0;
            act_q   <= 1'b0;
            mode_q  <= '0;
            rgb_q   <= '0;
            s_vld_q <= 1'b0;
            s_x_q   <= '0;
            s_y_q   <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            dat_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            a_q     <= a_d;
            act_q   <= act_d;
            mode_q  <= mode_d;
            rgb_q   <= rgb_d;
            s_vld_q <= s_vld_d;
            s_x_q   <= s_x_d;
            s_y_q   <= s_y_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign data          = dat_q;
    assign startofpacket = sop_q;
    assign endofpacket   = eop_q;
    assign valid         = vld_q;
    assign frame_count   = cnt_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_frame_pattern_streamer.sv
// tb_frame_pattern_streamer: directed checks of the frame streamer at WIDTH=8, HEIGHT=4.
module tb_frame_pattern_streamer;
    logic        clk = 0, reset_n = 0, enable = 0, ready = 1;
    logic [2:0]  mode = 0;
    logic [11:0] solid_rgb = 0;
    logic [29:0] data;
    logic        startofpacket, endofpacket, valid, busy;
    logic [15:0] frame_count;
    int n_cmp = 0, n_bad = 0;

    // Colour bars white, yellow, cyan, green, magenta, red, blue, black after 4->10 expansion.
    logic [29:0] bars [8] = '{30'h3FFFFFFF, 30'h3FFFFC00, 30'h000FFFFF, 30'h000FFC00,
                              30'h3FF003FF, 30'h3FF00000, 30'h000003FF, 30'h00000000};
    // Gradient channel x>>1 = 0..3 expanded 4->10.
    logic [9:0] gexp [4] = '{10'h000, 10'h044, 10'h088, 10'h0CC};

    always #5 clk = ~clk;

    frame_pattern_streamer #(.WIDTH(8), .HEIGHT(4), .IN_BITS(4), .OUT_BITS(10), .ROM_FILE(""),
                             .GRAD_SHIFT(1), .CHECK_SHIFT(1)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
        .data(data), .startofpacket(startofpacket), .endofpacket(endofpacket), .valid(valid),
        .ready(ready), .frame_count(frame_count), .busy(busy));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] m, input logic [11:0] rgb, input logic en);
        reset_n = 0; mode = m; solid_rgb = rgb; enable = en; ready = 1;
        step; step;
        reset_n = 1;
    endtask

    task automatic test_reset;
        reset_n = 0; enable = 1; mode = 1; solid_rgb = 12'hF00; ready = 1;
        step;
        n_cmp++; if ({valid, startofpacket, endofpacket, busy} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {valid, startofpacket, endofpacket, busy}); end
        n_cmp++; if (data !== 30'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data); end
        n_cmp++; if (frame_count !== 16'h0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", frame_count); end
        reset_n = 1;
        step;
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL startup_edge1_valid: got %b want 0", valid); end
        step;
        n_cmp++; if (valid !== 1'b1 || startofpacket !== 1'b1) begin n_bad++; $display("FAIL startup_sop: got v=%b sop=%b want 1 1", valid, startofpacket); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL startup_busy: got %b want 1", busy); end
        for (int b = 0; b < 32; b++) begin
            n_cmp++; if (data !== 30'h3FF00000) begin n_bad++; $display("FAIL solid_data beat %0d: got %h want 3ff00000", b, data); end
            n_cmp++; if (endofpacket !== (b == 31)) begin n_bad++; $display("FAIL solid_eop beat %0d: got %b want %b", b, endofpacket, b == 31); end
            step;
        end
        n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL solid_count: got %0d want 1", frame_count); end
        n_cmp++; if (valid !== 1'b1 || startofpacket !== 1'b1) begin n_bad++; $display("FAIL back_to_back_sop: got v=%b sop=%b want 1 1", valid, startofpacket); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL back_to_back_busy: got %b want 1", busy); end
    endtask

    task automatic test_backpressure;
        int acc = 0, i, x, y;
        logic held = 0;
        logic [32:0] snap = '0;
        logic [9:0] ch;
        do_reset(2, 12'h0, 1);
        for (int c = 0; c < 800 && acc < 64; c++) begin
            step;
            n_cmp++; if (held && {data, startofpacket, endofpacket, valid} !== snap) begin n_bad++; $display("FAIL stall_hold cycle %0d: got %h want %h", c, {data, startofpacket, endofpacket, valid}, snap); end
            ready = 1'($urandom_range(0, 1));
            if (valid && ready) begin
                i = acc % 32; x = i % 8; y = i / 8; ch = gexp[x >> 1];
                n_cmp++; if (data !== {ch, ch, ch}) begin n_bad++; $display("FAIL grad_data beat %0d (x=%0d y=%0d): got %h want %h", acc, x, y, data, {ch, ch, ch}); end
                n_cmp++; if (startofpacket !== (i == 0) || endofpacket !== (i == 31)) begin n_bad++; $display("FAIL grad_sop_eop beat %0d: got %b%b want %b%b", acc, startofpacket, endofpacket, i == 0, i == 31); end
                if (x == 5) begin
                    n_cmp++; if (data[9:0] !== 10'h088) begin n_bad++; $display("FAIL grad_x5: got %h want 088", data[9:0]); end
                end
                acc++;
            end
            held = valid && !ready;
            snap = {data, startofpacket, endofpacket, valid};
        end
        n_cmp++; if (acc !== 64) begin n_bad++; $display("FAIL grad_beats: got %0d want 64 (timeout)", acc); end
        step;
        n_cmp++; if (frame_count !== 16'd2) begin n_bad++; $display("FAIL grad_count: got %0d want 2", frame_count); end
        ready = 1;
    endtask

    task automatic test_mode_change;
        int x, y;
        logic [29:0] exp_d;
        do_reset(3, 12'h0, 1);
        step; step;
        for (int b = 0; b < 32; b++) begin
            if (b == 10) mode = 4;
            n_cmp++; if (data !== bars[b % 8]) begin n_bad++; $display("FAIL bars_data beat %0d: got %h want %h", b, data, bars[b % 8]); end
            step;
        end
        for (int b = 0; b < 32; b++) begin
            x = b % 8; y = b / 8;
            exp_d = (((x >> 1) ^ (y >> 1)) & 1) != 0 ? 30'h3FFFFFFF : 30'h0;
            n_cmp++; if (data !== exp_d) begin n_bad++; $display("FAIL checker_data (%0d,%0d): got %h want %h", x, y, data, exp_d); end
            if (b == 0) begin
                n_cmp++; if (startofpacket !== 1'b1 || data !== 30'h0) begin n_bad++; $display("FAIL checker_00: got sop=%b %h want 1 0", startofpacket, data); end
            end
            if (b == 2) begin
                n_cmp++; if (data !== 30'h3FFFFFFF) begin n_bad++; $display("FAIL checker_20: got %h want 3fffffff", data); end
            end
            if (b == 18) begin
                n_cmp++; if (data !== 30'h0) begin n_bad++; $display("FAIL checker_22: got %h want 0", data); end
            end
            step;
        end
    endtask

    task automatic test_enable_drop;
        do_reset(1, 12'h0F0, 1);
        step; step;
        for (int b = 0; b < 32; b++) begin
            if (b == 5) enable = 0;
            n_cmp++; if (valid !== 1'b1 || endofpacket !== (b == 31)) begin n_bad++; $display("FAIL drop_frame beat %0d: got v=%b eop=%b", b, valid, endofpacket); end
            step;
        end
        n_cmp++; if (valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL drop_idle: got v=%b busy=%b want 0 0", valid, busy); end
        n_cmp++; if (data !== 30'h000FFC00) begin n_bad++; $display("FAIL drop_hold_data: got %h want 000ffc00", data); end
        n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL drop_count: got %0d want 1", frame_count); end
        repeat (5) step;
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL drop_stay_idle: got %b want 0", valid); end
        enable = 1;
        step;
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reenable_edge1: got %b want 0", valid); end
        step;
        n_cmp++; if (valid !== 1'b1 || startofpacket !== 1'b1) begin n_bad++; $display("FAIL reenable_sop: got v=%b sop=%b want 1 1", valid, startofpacket); end
        for (int b = 0; b < 32; b++) begin
            n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL reenable_count beat %0d: got %0d want 1", b, frame_count); end
            step;
        end
        n_cmp++; if (frame_count !== 16'd2) begin n_bad++; $display("FAIL reenable_count_end: got %0d want 2", frame_count); end
    endtask

    task automatic test_reset_mid;
        do_reset(1, 12'hF00, 1);
        step; step;
        repeat (32 + 17) step;
        n_cmp++; if (valid !== 1'b1 || frame_count !== 16'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL midreset_pre: got v=%b fc=%0d busy=%b want 1 1 1", valid, frame_count, busy); end
        reset_n = 0;
        #1;
        n_cmp++; if ({valid, startofpacket, endofpacket, busy} !== 4'b0 || data !== 30'h0) begin n_bad++; $display("FAIL midreset_async: got flags=%b data=%h want 0 0", {valid, startofpacket, endofpacket, busy}, data); end
        n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL midreset_count: got %0d want 0", frame_count); end
        repeat (3) step;
        reset_n = 1;
        step;
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL midreset_edge1: got %b want 0", valid); end
        step;
        n_cmp++; if (valid !== 1'b1 || startofpacket !== 1'b1 || data !== 30'h3FF00000) begin n_bad++; $display("FAIL midreset_sop: got v=%b sop=%b %h want 1 1 3ff00000", valid, startofpacket, data); end
    endtask

    task automatic test_rom_mode;
        do_reset(5, 12'hFFF, 1);
        step; step;
        for (int b = 0; b < 32; b++) begin
            if (b == 1) enable = 0;
            n_cmp++; if (valid !== 1'b1 || startofpacket !== (b == 0) || endofpacket !== (b == 31)) begin n_bad++; $display("FAIL rom_frame beat %0d: got v=%b sop=%b eop=%b", b, valid, startofpacket, endofpacket); end
            step;
        end
        n_cmp++; if (valid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd1) begin n_bad++; $display("FAIL rom_end: got v=%b busy=%b fc=%0d want 0 0 1", valid, busy, frame_count); end
    endtask

    initial begin
        test_reset;
        test_backpressure;
        test_mode_change;
        test_enable_drop;
        test_reset_mid;
        test_rom_mode;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
